aes256_key_expand_ctrl: RTL and testbench
=========================================

Name: aes256_key_expand_ctrl

Overview:
Sequencer for the AES-256 key schedule. It accepts a 256-bit cipher key and emits all 60 expanded words w[0..59] into the round-key RAM, one word per cycle. It applies RotWord, Rcon and SubWord in the FIPS-197 order. SubWord is an external combinational S-box word port, so the cipher datapath can share the same S-box bank while this block is idle.

Parameters:
NK, 8, key length in 32-bit words (fixed at 8 for AES-256; other values unsupported)
NW, 60, total expanded words (4*(14+1))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request expansion; sampled only in IDLE
key  in  256  cipher key, key[255:224] = w[0]; captured on accepted start
busy  out  1  high from the cycle after start acceptance through DONE
done  out  1  one-cycle pulse after w[59] is written
rk_we  out  1  round-key RAM write enable
rk_addr  out  6  word index 0..59
rk_data  out  32  word value
sw_in  out  32  word presented to the external SubWord unit
sw_out  in  32  SubWord(sw_in), combinational, same cycle
sw_active  out  1  high while sw_in is meaningful (S-box arbitration hint)

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, rk_we=0, rk_addr=0, rk_data=0, sw_in=0, sw_active=0; window and rcon are cleared.
- States: IDLE -> LOAD (start=1 in IDLE) -> EXPAND (after word 7) -> DONE (after word 59) -> IDLE (next cycle).
- IDLE: start=1 captures key into an 8-word window register (win[0]=w[i-8] ... win[7]=w[i-1]), sets i=0 and rcon=8'h01.
- LOAD: 8 cycles; cycle k asserts rk_we=1, rk_addr=k, rk_data=key word k.
- EXPAND: 52 cycles, i=8..59, one word per cycle, rk_we=1, rk_addr=i.
  - temp=win[7].
  - If i%8==0: sw_in=RotWord(temp)={temp[23:0],temp[31:24]}; temp'=sw_out ^ {rcon,24'h0}; rcon then doubles (GF(2^8) xtime; only values 01..40 are ever used).
  - If i%8==4: sw_in=temp; temp'=sw_out.
  - Otherwise: temp'=temp, sw_in=0, sw_active=0.
  - w[i]=win[0]^temp'; rk_data=w[i]; the window shifts left by one word and appends w[i].
  - sw_active=1 exactly in the cycles where i%8 is 0 or 4.
- DONE: rk_we=0, done=1 for one cycle, busy=1; the next state is IDLE with busy=0.
- Latency: start accepted at cycle T; w[0] is written at T+1; w[59] at T+60; done=1 at T+61.
- start while busy (including DONE) is ignored, with no queuing. A new start is legal in the first IDLE cycle after DONE.
- rst asserted mid-operation aborts immediately: no further writes, and the RAM contents are partial and undefined to consumers.
- rk_addr wraps never: it reaches 59 and then holds until the next start. All address arithmetic is 6-bit unsigned.

Decomposition:
- Package aes_key_pkg holds NK, NW, the state enum (IDLE, LOAD, EXPAND, DONE), the xtime function, and the rot_word function (8-bit left byte rotation).
- One natural sub-module: aes_key_window. It is the 8x32 shift register with parallel load, and exposes the head (w[i-8]) and tail (w[i-1]).
- The S-box stays outside this block.

Test Plan:
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, start pulse -> rk_addr 0..7 echo the key; w8=9ba35411, w9=8e6925af, w10=a51a8b5f, w11=2067fcde.
- Same run, SubWord-only path -> w12=a8b09c1a with sw_active=1 and sw_in=0914dff4 ^ ... (sw_in = w11 = 2067fcde); w56=fe4890d1, w59=706c631e; done pulses exactly at T+61.
- All-zero key -> w8=62636363, w9..w11=62636363, and sw_in=00000000 at i=8.
- start held high continuously for 200 cycles -> back-to-back expansions: one idle cycle between DONE and the next w[0] write, with no writes during that idle cycle.
- rst asserted at i=30 -> rk_we=0 and busy=0 asynchronously; after release, start produces the full correct schedule from w[0].
- Scoreboard check: exactly 60 rk_we pulses per run, addresses strictly increasing 0..59, and sw_active asserted on exactly 13 cycles.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Purpose: shared constants, FSM state codes and byte helpers for the AES-256 key schedule.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_key_pkg;

  localparam int NK = 8;   // key length in 32-bit words (AES-256 only)
  localparam int NW = 60;  // total expanded words, 4*(14+1)

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EXPAND = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One-byte left rotation of a word: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_window.sv
// Purpose: 8x32 sliding window holding w[i-8]..w[i-1], parallel load from the cipher key.
// Latency: load/shift take effect on the next clock edge; head/tail are direct register taps.
// Backpressure: none; the controller shifts exactly once per emitted word.
module aes_key_window
  import aes_key_pkg::*;
(
  input  logic                the_unused_guard_never = 1'b0,
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [32*NK-1:0]    i_key,
  input  logic                i_shift,
  input  logic [31:0]         i_in,
  output logic [31:0]         o_head,
  output logic [31:0]         o_tail
);

  logic [31:0] r_win [NK];

  // Window register: clear on reset, parallel load of the key, or shift left appending i_in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
    end else if (i_load) begin
      for (int k = 0; k < NK; k++) r_win[k] <= i_key[32*(NK-1-k) +: 32];
    end else if (i_shift) begin
      for (int k = 0; k < NK-1; k++) r_win[k] <= r_win[k+1];
      r_win[NK-1] <= i_in;
    end
  end

  assign o_head = r_win[0];
  assign o_tail = r_win[NK-1];

endmodule

// File: rtl/aes256_key_expand_ctrl.sv
// Purpose: AES-256 key schedule sequencer writing w[0..59] to the round-key RAM, one word per cycle.
// Latency: start accepted in cycle T -> w[0] at T+1, w[59] at T+60, done pulse at T+61.
// Backpressure: none; start is ignored while busy, and the S-box port must answer combinationally.
module aes256_key_expand_ctrl
  import aes_key_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [255:0] i_key,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_rk_we,
  output logic [5:0]   o_rk_addr,
  output logic [31:0]  o_rk_data,
  output logic [31:0]  o_sw_in,
  input  logic [31:0]  i_sw_out,
  output logic         o_sw_active
);

  localparam logic [5:0] LAST_LOAD = 6'(NK - 1);
  localparam logic [5:0] LAST_WORD = 6'(NW - 1);

  logic [1:0]  r_state;
  logic [5:0]  r_i;
  logic [7:0]  r_rcon;

  logic        w_accept;
  logic        w_load_ph;
  logic        w_exp_ph;
  logic        w_rcon_step;
  logic        w_sub_step;
  logic [31:0] w_head;
  logic [31:0] w_tail;
  logic [31:0] w_temp;
  logic [31:0] w_word;
  logic [31:0] w_shift_in;

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_load_ph   = (r_state == ST_LOAD);
  assign w_exp_ph    = (r_state == ST_EXPAND);
  assign w_rcon_step = w_exp_ph && (r_i[2:0] == 3'd0);
  assign w_sub_step  = w_exp_ph && (r_i[2:0] == 3'd4);

  // S-box request and transformed temp word; sw_in stays zero when no substitution is needed.
  always_comb begin
    o_sw_in = '0;
    w_temp  = w_tail;
    if (w_rcon_step) begin
      o_sw_in = rot_word(w_tail);
      w_temp  = i_sw_out ^ {r_rcon, 24'h0};
    end else if (w_sub_step) begin
      o_sw_in = w_tail;
      w_temp  = i_sw_out;
    end
  end

  assign w_word = w_head ^ w_temp;

  // During LOAD the window rotates so that after 8 words it holds the key again in order.
  assign w_shift_in = w_exp_ph ? w_word : w_head;

  aes_key_window u_window (
    .the_unused_guard_never (1'b0),
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_key   (i_key),
    .i_shift (o_rk_we),
    .i_in    (w_shift_in),
    .o_head  (w_head),
    .o_tail  (w_tail)
  );

  // Sequencer: state, word index (doubles as RAM address, holds at 59) and round constant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_rcon  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_i     <= '0;
            r_rcon  <= 8'h01;
          end
        end
        ST_LOAD: begin
          r_i <= r_i + 6'd1;
          if (r_i == LAST_LOAD) r_state <= ST_EXPAND;
        end
        ST_EXPAND: begin
          if (w_rcon_step) r_rcon <= xtime(r_rcon);
          if (r_i == LAST_WORD) r_state <= ST_DONE;
          else                  r_i     <= r_i + 6'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_rk_we     = w_load_ph | w_exp_ph;
  assign o_rk_addr   = r_i;
  assign o_rk_data   = w_load_ph ? w_head : (w_exp_ph ? w_word : 32'h0);
  assign o_sw_active = w_rcon_step | w_sub_step;

endmodule

// File: tb/tb_aes256_key_expand_ctrl.sv
// Purpose: self-checking bench for aes256_key_expand_ctrl against a FIPS-197 key-schedule model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_aes256_key_expand_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic         busy, done, rk_we, sw_active;
  logic [5:0]   rk_addr;
  logic [31:0]  rk_data, sw_in, sw_out;

  logic [7:0]   sbox [256];
  logic [31:0]  m_w [0:59];
  int           m_k;       // 0 idle, 1..60 writing w[m_k-1], 61 done
  logic [5:0]   m_addr;
  logic [31:0]  ram [0:63];
  logic [31:0]  swlog [0:63];
  int           n_chk, n_fail;
  int           ncyc, t_busy, n_rise, n_we, n_sw, prev_addr;
  logic         prev_busy;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  aes256_key_expand_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_key(key),
    .o_busy(busy), .o_done(done), .o_rk_we(rk_we), .o_rk_addr(rk_addr),
    .o_rk_data(rk_data), .o_sw_in(sw_in), .i_sw_out(sw_out), .o_sw_active(sw_active)
  );

  assign sw_out = {sbox[sw_in[31:24]], sbox[sw_in[23:16]], sbox[sw_in[15:8]], sbox[sw_in[7:0]]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
    logic [15:0] d;
    d = {b, b} << s;
    return d[15:8];
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion written straight from the standard's pseudocode.
  task automatic expand(input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int n = 0; n < 8; n++) m_w[n] = k[255 - 32*n -: 32];
    rc = 8'h01;
    for (int n = 8; n < 60; n++) begin
      t = m_w[n-1];
      if (n % 8 == 0) begin
        t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (n % 8 == 4) begin
        t = sub_w(t);
      end
      m_w[n] = m_w[n-8] ^ t;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference sequencing: which word (if any) must be on the bus in the coming cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k    = 0;
      m_addr = 6'd0;
    end else begin
      if (m_k == 0) begin
        if (start) begin
          expand(key);
          m_k = 1;
        end
      end else if (m_k == 61) begin
        m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
      if (m_k >= 1 && m_k <= 60) m_addr = 6'(m_k - 1);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int          idx;
    logic        e_we, e_act;
    logic [31:0] e_sw, e_dat;
    ncyc++;
    e_we  = (m_k >= 1 && m_k <= 60);
    idx   = m_k - 1;
    e_sw  = 32'h0;
    e_act = 1'b0;
    e_dat = 32'h0;
    if (e_we) e_dat = m_w[idx];
    if (e_we && idx >= 8 && idx % 8 == 0) begin
      e_sw = {m_w[idx-1][23:0], m_w[idx-1][31:24]}; e_act = 1'b1;
    end else if (e_we && idx >= 8 && idx % 8 == 4) begin
      e_sw = m_w[idx-1]; e_act = 1'b1;
    end
    chk("rk_we",     32'(rk_we),     32'(e_we));
    chk("busy",      32'(busy),      32'(m_k != 0));
    chk("done",      32'(done),      32'(m_k == 61));
    chk("rk_addr",   32'(rk_addr),   32'(m_addr));
    chk("rk_data",   rk_data,        e_dat);
    chk("sw_in",     sw_in,          e_sw);
    chk("sw_active", 32'(sw_active), 32'(e_act));
    // Per-run scoreboard keyed off what the DUT actually shows.
    if (busy && !prev_busy) begin
      n_rise++; t_busy = ncyc; n_we = 0; n_sw = 0; prev_addr = -1;
    end
    if (rk_we) begin
      chk("addr_step", 32'(rk_addr), 32'(prev_addr + 1));
      prev_addr = int'(rk_addr);
      n_we++;
      ram[rk_addr]   = rk_data;
      swlog[rk_addr] = sw_in;
    end
    if (sw_active) n_sw++;
    if (done) begin
      chk("we_count", 32'(n_we), 32'd60);
      chk("sw_count", 32'(n_sw), 32'd13);
      // busy first seen at T+1, done at T+61
      chk("done_latency", 32'(ncyc - t_busy), 32'd60);
    end
    prev_busy = busy;
  end

  task automatic pulse_start(input logic [255:0] k);
    @(posedge clk); #1;
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < limit);
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done timeout after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rk;
    int           n;
    n_chk = 0; n_fail = 0; ncyc = 0; n_rise = 0; prev_busy = 1'b0;
    n_we = 0; n_sw = 0; prev_addr = -1; t_busy = 0; m_k = 0; m_addr = 6'd0;
    rst = 1'b1; start = 1'b0; key = '0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      end
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = b;
    end
    chk("sbox_00", 32'(sbox[8'h00]), 32'h63);
    chk("sbox_53", 32'(sbox[8'h53]), 32'hed);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // FIPS-197 A.3 vector
    pulse_start(FIPS_KEY);
    wait_done(200);
    rk = FIPS_KEY;
    for (int j = 0; j < 8; j++) chk("key_echo", ram[j], rk[255 - 32*j -: 32]);
    chk("w8",  ram[8],  32'h9ba35411);
    chk("w9",  ram[9],  32'h8e6925af);
    chk("w10", ram[10], 32'ha51a8b5f);
    chk("w11", ram[11], 32'h2067fcde);
    chk("w12", ram[12], 32'ha8b09c1a);
    chk("sw_in_w12", swlog[12], 32'h2067fcde);
    chk("w56", ram[56], 32'hfe4890d1);
    chk("w59", ram[59], 32'h706c631e);

    // all-zero key
    pulse_start('0);
    wait_done(200);
    for (int j = 8; j < 12; j++) chk("zero_w8_11", ram[j], 32'h62636363);
    chk("zero_sw_in_w8", swlog[8], 32'h0);

    // start held high: back-to-back runs, keys changing every cycle
    @(posedge clk); #1;
    n_rise = 0; start = 1'b1;
    repeat (200) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(200);
    chk("held_start_runs", 32'(n_rise), 32'd4);

    // reset in the middle of a run
    pulse_start({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rk_we && rk_addr == 6'd30) && n < 100);
    chk("reached_i30", 32'(rk_addr), 32'd30);
    #1 rst = 1'b1;
    #1;
    chk("abort_rk_we", 32'(rk_we), 32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    @(posedge clk); #1 rst = 1'b0;
    pulse_start(FIPS_KEY);
    wait_done(200);
    chk("after_rst_w0",  ram[0],  32'h603deb10);
    chk("after_rst_w59", ram[59], 32'h706c631e);

    // random keys with stray start pulses while busy
    for (int r = 0; r < 4; r++) begin
      pulse_start({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      repeat (50) begin
        start = ($urandom_range(0, 2) == 0);
        key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
      end
      start = 1'b0;
      wait_done(200);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
